// File: rtl/led_rp_pkg.sv
// led_rp_pkg: shared types and defaults for the LED reconfigurable-partition sequencer
package led_rp_pkg;
  localparam int STATE_W = 2;
  localparam int TICK_W_DEF = 25;
  localparam int RST_HOLD_DEF = 16;
  localparam int SETTLE_DEF = 4;
  typedef enum logic [STATE_W-1:0] {
    ST_RUN       = 2'd0,
    ST_DECOUPLED = 2'd1,
    ST_RM_RESET  = 2'd2,
    ST_SETTLE    = 2'd3
  } state_t;
endpackage

// File: rtl/led_rp_ctrl_tick_gen.sv
// tick_gen: free-running prescaler that strobes tick on its all-ones count while enabled
module tick_gen #(
  parameter int TICK_W = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [TICK_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tick = en & (&cnt);
endmodule

// File: rtl/led_rp_ctrl.sv
// led_rp_ctrl: sequences decouple, RM reset and tick around partial reconfiguration of the LED RP
module led_rp_ctrl
  import led_rp_pkg::*;
#(
  parameter int TICK_W   = TICK_W_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF,
  parameter int SETTLE   = SETTLE_DEF,
  parameter int LED_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pr_req,
  input  logic               pr_done,
  input  logic [LED_W-1:0]   rm_led_in,
  output logic               pr_ack,
  output logic               decouple,
  output logic               rm_rst_n,
  output logic               tick,
  output logic [LED_W-1:0]   led_out,
  output logic [STATE_W-1:0] state_o,
  output logic               err
);
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic run, term;
  assign run = state == ST_RUN;
  assign term = cnt == (state == ST_RM_RESET ? 8'(RST_HOLD - 1) : 8'(SETTLE - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= ST_RM_RESET;
      cnt     <= '0;
      led_out <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (run) led_out <= rm_led_in;
      if (pr_done && state != ST_DECOUPLED) err <= 1'b1;
    end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_RUN: state_nx = pr_req ? ST_DECOUPLED : ST_RUN;
      ST_DECOUPLED: begin
        state_nx = pr_done ? ST_RM_RESET : ST_DECOUPLED;
        cnt_nx   = '0;
      end
      ST_RM_RESET: begin
        state_nx = term ? ST_SETTLE : ST_RM_RESET;
        cnt_nx   = term ? '0 : cnt + 8'd1;
      end
      ST_SETTLE: begin
        state_nx = term ? ST_RUN : ST_SETTLE;
        cnt_nx   = term ? '0 : cnt + 8'd1;
      end
    endcase
    decouple = !run;
    pr_ack   = state == ST_DECOUPLED;
    rm_rst_n = state != ST_RM_RESET;
    state_o  = state;
  end
  // prescaler restarts on SETTLE exit so every RUN period begins with a full tick interval
  tick_gen #(.TICK_W(TICK_W)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (run),
    .clr (state == ST_SETTLE && term),
    .tick(tick)
  );
endmodule

// File: tb/tb_led_rp_ctrl.sv
// tb_led_rp_ctrl: directed table-driven check of the LED RP sequencer
module tb_led_rp_ctrl;
  logic clk, rst, pr_req, pr_done, pr_ack, decouple, rm_rst_n, tick, err;
  logic [3:0] rm_led_in, led_out;
  logic [1:0] state_o;
  logic [10:0] outs;
  int n_vec, n_err;

  typedef struct {
    logic        req;
    logic        done;
    logic [3:0]  li;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[23];

  led_rp_ctrl #(.TICK_W(4), .RST_HOLD(4), .SETTLE(2), .LED_W(4)) dut (
    .clk(clk), .rst(rst), .pr_req(pr_req), .pr_done(pr_done), .rm_led_in(rm_led_in),
    .pr_ack(pr_ack), .decouple(decouple), .rm_rst_n(rm_rst_n), .tick(tick),
    .led_out(led_out), .state_o(state_o), .err(err)
  );

  assign outs = {state_o, decouple, pr_ack, rm_rst_n, tick, led_out, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, decouple, pr_ack, rm_rst_n, tick, led_out, err}
  function automatic logic [10:0] pk(input int st, input int dec, input int ack, input int rn,
                                     input int tk, input int lo, input int er);
    return {st[1:0], dec[0], ack[0], rn[0], tk[0], lo[3:0], er[0]};
  endfunction

  function automatic vec_t mk(input int req, input int done, input int li, input logic [10:0] e);
    vec_t v;
    v.req = req[0];
    v.done = done[0];
    v.li = li[3:0];
    v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_seq(input string tag);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("%s_%0d", tag, i), outs,
          i < 3 ? pk(2, 1, 0, 0, 0, 0, 0) : i < 5 ? pk(3, 1, 0, 1, 0, 0, 0) : pk(0, 0, 0, 1, 0, 0, 0));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl[0] = mk(1, 0, 'hA, pk(1, 1, 1, 1, 0, 'hA, 0));
    tbl[1] = mk(1, 0, 'h3, pk(1, 1, 1, 1, 0, 'hA, 0));
    for (int i = 2; i < 12; i++) tbl[i] = mk(0, 0, 'h3, pk(1, 1, 1, 1, 0, 'hA, 0));
    tbl[12] = mk(0, 1, 'h3, pk(2, 1, 0, 0, 0, 'hA, 0));
    for (int i = 13; i < 16; i++) tbl[i] = mk(0, 0, 'h3, pk(2, 1, 0, 0, 0, 'hA, 0));
    tbl[16] = mk(0, 0, 'h3, pk(3, 1, 0, 1, 0, 'hA, 0));
    tbl[17] = mk(0, 0, 'h3, pk(3, 1, 0, 1, 0, 'hA, 0));
    tbl[18] = mk(0, 0, 'h3, pk(0, 0, 0, 1, 0, 'hA, 0));
    tbl[19] = mk(0, 0, 'h3, pk(0, 0, 0, 1, 0, 'h3, 0));
    tbl[20] = mk(0, 1, 'h3, pk(0, 0, 0, 1, 0, 'h3, 1));
    tbl[21] = mk(0, 0, 'h3, pk(0, 0, 0, 1, 0, 'h3, 1));
    tbl[22] = mk(0, 0, 'h3, pk(0, 0, 0, 1, 0, 'h3, 1));

    rst = 1'b0;
    pr_req = 1'b0;
    pr_done = 1'b0;
    rm_led_in = 4'hA;
    step();
    step();
    chk("reset", outs, pk(2, 1, 0, 0, 0, 0, 0));
    rst = 1'b1;
    rst_seq("boot");

    // RUN entered: prescaler starts at 0, tick on the 16th RUN cycle and every 16 after
    for (int i = 0; i < 32; i++) begin
      if (i > 0) step();
      chk($sformatf("tick_%0d", i), 11'(tick), 11'(i % 16 == 15));
      if (i < 2) chk($sformatf("led_lat_%0d", i), 11'(led_out), i == 0 ? 11'h0 : 11'hA);
    end

    pr_req = 1'b1;
    #1;
    chk("tick_with_req", 11'(tick), 11'd1);
    for (int i = 0; i < 23; i++) begin
      pr_req = tbl[i].req;
      pr_done = tbl[i].done;
      rm_led_in = tbl[i].li;
      step();
      chk($sformatf("vec_%0d", i), outs, tbl[i].exp);
    end

    // back-to-back reconfiguration with pr_req never dropping
    pr_req = 1'b1;
    step();
    chk("b2b_dec", outs, pk(1, 1, 1, 1, 0, 3, 1));
    pr_done = 1'b1;
    step();
    chk("b2b_rr", outs, pk(2, 1, 0, 0, 0, 3, 1));
    pr_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("b2b_%0d", i), outs,
          i < 3 ? pk(2, 1, 0, 0, 0, 3, 1) : i < 5 ? pk(3, 1, 0, 1, 0, 3, 1) : pk(0, 0, 0, 1, 0, 3, 1));
    end
    step();
    chk("b2b_redec", outs, pk(1, 1, 1, 1, 0, 3, 1));

    // reset hit in RM_RESET with hold counter at 2
    pr_req = 1'b0;
    pr_done = 1'b1;
    step();
    pr_done = 1'b0;
    step();
    step();
    chk("mid_rr", outs, pk(2, 1, 0, 0, 0, 3, 1));
    rst = 1'b0;
    #1;
    chk("mid_rst", outs, pk(2, 1, 0, 0, 0, 0, 0));
    step();
    chk("mid_rst_hold", outs, pk(2, 1, 0, 0, 0, 0, 0));
    rst = 1'b1;
    rst_seq("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
